// File: rtl/issue_sequencer.sv
// issue_sequencer
//   Holds one fetch bundle of up to NUM_WIDTH instructions and issues the
//   oldest-first prefix of it that the external dependency checker clears.
//   Unissued slots shift down so slot 0 is always the oldest instruction.
//
// State table
//   state    | meaning
//   S_IDLE   | no valid slot held; a new bundle may be accepted
//   S_ACTIVE | at least one valid slot held, waiting to issue
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous buffer clear (redirect), highest priority
//   in_valid/in_ready   fetch bundle handshake
//   in_count            valid slots in bundle, lowest index first
//   in_inst/rd/rs1/rs2  bundle instruction and register fields
//   chk_rd/rs1/rs2      held slot fields to the dependency checker (zero if invalid)
//   dep_can_issue       checker result per lane (lane 0 ignored)
//   ex_ready            execute stage accepts an issue this cycle
//   iss_valid           per-lane issue strobe (always a prefix)
//   iss_inst/rd/rs1/rs2 issued instruction and fields per lane
//   perf_split_cnt      saturating count of dependency-split issue cycles
module issue_sequencer #(
    parameter int NUM_WIDTH  = 3,
    parameter int REG_WIDTH  = 5,
    parameter int INST_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [1:0]                            in_count,
    input  logic [NUM_WIDTH-1:0][INST_WIDTH-1:0]  in_inst,
    input  logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]   in_rd,
    input  logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]   in_rs1,
    input  logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]   in_rs2,
    output logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]   chk_rd,
    output logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]   chk_rs1,
    output logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]   chk_rs2,
    input  logic [NUM_WIDTH-1:0]                  dep_can_issue,
    input  logic                                  ex_ready,
    output logic [NUM_WIDTH-1:0]                  iss_valid,
    output logic [NUM_WIDTH-1:0][INST_WIDTH-1:0]  iss_inst,
    output logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]   iss_rd,
    output logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]   iss_rs1,
    output logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]   iss_rs2,
    output logic [7:0]                            perf_split_cnt
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]                           state_q, state_d;
    logic [NUM_WIDTH-1:0]                 slot_v_q, slot_v_d;
    logic [NUM_WIDTH-1:0][INST_WIDTH-1:0] slot_inst_q, slot_inst_d;
    logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]  slot_rd_q, slot_rd_d;
    logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]  slot_rs1_q, slot_rs1_d;
    logic [NUM_WIDTH-1:0][REG_WIDTH-1:0]  slot_rs2_q, slot_rs2_d;
    logic [7:0]                           split_cnt_q, split_cnt_d;

    logic [NUM_WIDTH-1:0] iss_mask;
    logic                 lane_ok;
    logic                 all_issue;
    logic                 accept;
    int                   n_iss;
    int                   n_valid;
    int                   cnt_clamp;

    // Issue mask: a lane issues only if every older lane issues too, so the
    // issued set is always a prefix of the held slots.
    always_comb begin
        iss_mask = '0;
        n_iss    = 0;
        n_valid  = 0;
        lane_ok  = ex_ready & ~flush;
        for (int i = 0; i < NUM_WIDTH; i++) begin
            lane_ok     = lane_ok & slot_v_q[i] & ((i == 0) || dep_can_issue[i]);
            iss_mask[i] = lane_ok;
            n_iss       = n_iss + int'(lane_ok);
            n_valid     = n_valid + int'(slot_v_q[i]);
        end
        all_issue = (iss_mask == slot_v_q);
        in_ready  = ~flush & ((state_q == S_IDLE) | all_issue);
        cnt_clamp = (int'(in_count) > NUM_WIDTH) ? NUM_WIDTH : int'(in_count);
        accept    = in_valid & in_ready & (in_count != 2'd0);
    end

    always_comb begin
        slot_v_d    = '0;
        slot_inst_d = '0;
        slot_rd_d   = '0;
        slot_rs1_d  = '0;
        slot_rs2_d  = '0;
        // Shift unissued slots down by n_iss (source j lands in slot j-n_iss).
        for (int j = 0; j < NUM_WIDTH; j++) begin
            for (int i = 0; i <= j; i++) begin
                if (j - i == n_iss) begin
                    slot_v_d[i]    = slot_v_q[j];
                    slot_inst_d[i] = slot_inst_q[j];
                    slot_rd_d[i]   = slot_rd_q[j];
                    slot_rs1_d[i]  = slot_rs1_q[j];
                    slot_rs2_d[i]  = slot_rs2_q[j];
                end
            end
        end
        // Accept implies every held slot issues, so the new bundle replaces all.
        if (accept) begin
            for (int i = 0; i < NUM_WIDTH; i++) begin
                slot_v_d[i]    = (i < cnt_clamp);
                slot_inst_d[i] = in_inst[i];
                slot_rd_d[i]   = in_rd[i];
                slot_rs1_d[i]  = in_rs1[i];
                slot_rs2_d[i]  = in_rs2[i];
            end
        end
        if (flush) begin
            slot_v_d = '0;
        end

        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = accept ? S_ACTIVE : S_IDLE;
            S_ACTIVE: begin
                if (flush)          state_d = S_IDLE;
                else if (accept)    state_d = S_ACTIVE;
                else if (all_issue) state_d = S_IDLE;
                else                state_d = S_ACTIVE;
            end
            default:  state_d = S_IDLE;
        endcase

        split_cnt_d = split_cnt_q;
        if ((n_iss > 0) && (n_iss < n_valid) && (split_cnt_q != 8'hFF)) begin
            split_cnt_d = split_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_v_q    <= '0;
            slot_inst_q <= '0;
            slot_rd_q   <= '0;
            slot_rs1_q  <= '0;
            slot_rs2_q  <= '0;
            split_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            slot_v_q    <= slot_v_d;
            slot_inst_q <= slot_inst_d;
            slot_rd_q   <= slot_rd_d;
            slot_rs1_q  <= slot_rs1_d;
            slot_rs2_q  <= slot_rs2_d;
            split_cnt_q <= split_cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WIDTH; i++) begin
            chk_rd[i]  = slot_v_q[i] ? slot_rd_q[i]  : '0;
            chk_rs1[i] = slot_v_q[i] ? slot_rs1_q[i] : '0;
            chk_rs2[i] = slot_v_q[i] ? slot_rs2_q[i] : '0;
        end
    end

    assign iss_valid      = iss_mask;
    assign iss_inst       = slot_inst_q;
    assign iss_rd         = slot_rd_q;
    assign iss_rs1        = slot_rs1_q;
    assign iss_rs2        = slot_rs2_q;
    assign perf_split_cnt = split_cnt_q;

endmodule

// File: tb/tb_issue_sequencer.sv
module tb_issue_sequencer;
    localparam int N  = 3;
    localparam int RW = 5;
    localparam int IW = 32;

    typedef struct {
        logic [IW-1:0] inst;
        logic [RW-1:0] rd;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
    } item_t;

    typedef struct {
        logic [N-1:0]         mask;
        logic                 ready;
        logic [7:0]           split;
        logic [N-1:0][RW-1:0] crd;
        logic [N-1:0][RW-1:0] crs1;
        logic [N-1:0][RW-1:0] crs2;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [1:0] in_count = 2'd0;
    logic [N-1:0][IW-1:0] in_inst = '0;
    logic [N-1:0][RW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [N-1:0][RW-1:0] chk_rd, chk_rs1, chk_rs2;
    logic [N-1:0] dep_can_issue = '1;
    logic ex_ready = 1'b0;
    logic [N-1:0] iss_valid;
    logic [N-1:0][IW-1:0] iss_inst;
    logic [N-1:0][RW-1:0] iss_rd, iss_rs1, iss_rs2;
    logic [7:0] perf_split_cnt;

    issue_sequencer #(.NUM_WIDTH(N), .REG_WIDTH(RW), .INST_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .in_inst(in_inst), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .chk_rd(chk_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .dep_can_issue(dep_can_issue), .ex_ready(ex_ready),
        .iss_valid(iss_valid), .iss_inst(iss_inst), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .perf_split_cnt(perf_split_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    item_t held[$];      // reference model: instructions held, oldest first
    item_t exp_q[$];     // scoreboard: instructions expected to issue, in order
    rec_t  rec_q[$];     // per-cycle expected control outputs
    int    m_split = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a cycle.
    rec_t  mr;
    item_t mi;
    always @(negedge clk) begin
        if (rec_q.size() > 0) begin
            mr = rec_q.pop_front();
            check("iss_valid", 64'(iss_valid), 64'(mr.mask));
            check("in_ready", 64'(in_ready), 64'(mr.ready));
            check("split_cnt", 64'(perf_split_cnt), 64'(mr.split));
            check("chk_rd", 64'(chk_rd), 64'(mr.crd));
            check("chk_rs", 64'({chk_rs1, chk_rs2}), 64'({mr.crs1, mr.crs2}));
            for (int i = 0; i < N; i++) begin
                if (iss_valid[i]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_issue", 64'(i + 1), 64'd0);
                    end else begin
                        mi = exp_q.pop_front();
                        check("iss_inst", 64'(iss_inst[i]), 64'(mi.inst));
                        check("iss_regs", 64'({iss_rd[i], iss_rs1[i], iss_rs2[i]}),
                              64'({mi.rd, mi.rs1, mi.rs2}));
                    end
                end
            end
        end
    end

    // One cycle of stimulus plus the reference model step.
    // mode 0: random traffic; mode 1: only lane 0 ever cleared (forces splits).
    task automatic step(input int mode);
        logic       fl, er, iv;
        logic [1:0] cnt;
        logic [N-1:0] d;
        item_t b[N];
        rec_t  r;
        int    m, k, c;
        @(posedge clk);
        #1;
        fl  = (mode == 0) ? ($urandom_range(0, 99) < 7) : 1'b0;
        er  = (mode == 0) ? ($urandom_range(0, 99) < 80) : 1'b1;
        iv  = (mode == 0) ? ($urandom_range(0, 99) < 70) : 1'b1;
        cnt = (mode == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
        for (int i = 0; i < N; i++) begin
            b[i].inst = $urandom;
            b[i].rd   = RW'($urandom_range(0, 7));
            b[i].rs1  = RW'($urandom_range(0, 7));
            b[i].rs2  = RW'($urandom_range(0, 7));
        end
        // Bench plays the RAW checker over its own copy of the held slots.
        d = '1;
        for (int i = 1; i < held.size(); i++) begin
            for (int j = 0; j < i; j++) begin
                if (held[j].rd != 0 && (held[j].rd == held[i].rs1 || held[j].rd == held[i].rs2))
                    d[i] = 1'b0;
            end
        end
        if (mode == 0 && $urandom_range(0, 3) == 0) d = N'($urandom);
        if (mode == 1) d = 3'b001;

        flush = fl; ex_ready = er; in_valid = iv; in_count = cnt; dep_can_issue = d;
        for (int i = 0; i < N; i++) begin
            in_inst[i] = b[i].inst; in_rd[i] = b[i].rd;
            in_rs1[i] = b[i].rs1;   in_rs2[i] = b[i].rs2;
        end

        m = held.size();
        r.crd = '0; r.crs1 = '0; r.crs2 = '0;
        for (int i = 0; i < m; i++) begin
            r.crd[i] = held[i].rd; r.crs1[i] = held[i].rs1; r.crs2[i] = held[i].rs2;
        end
        r.split = 8'(m_split);
        k = 0;
        if (!fl && er) begin
            while (k < m && (k == 0 || d[k])) k++;
        end
        r.mask  = N'((1 << k) - 1);
        r.ready = !fl && (m == 0 || k == m);
        for (int i = 0; i < k; i++) exp_q.push_back(held[i]);
        if (k > 0 && k < m && m_split < 255) m_split++;
        for (int i = 0; i < k; i++) void'(held.pop_front());
        if (fl) held.delete();
        if (r.ready && iv && cnt != 0) begin
            c = (int'(cnt) > N) ? N : int'(cnt);
            held.delete();
            for (int i = 0; i < c; i++) held.push_back(b[i]);
        end
        rec_q.push_back(r);
    endtask

    initial begin
        #3;
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_split", 64'(perf_split_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 600; n++) step(0);
        for (int n = 0; n < 420; n++) step(1);
        @(negedge clk);
        check("split_saturated", 64'(perf_split_cnt), 64'd255);

        // Async reset with slots still held and issue otherwise enabled.
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1; dep_can_issue = '1;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_iss_valid", 64'(iss_valid), 64'd0);
        check("midrst_split", 64'(perf_split_cnt), 64'd0);
        held.delete();
        m_split = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 400; n++) step(0);

        @(posedge clk);
        #1;
        in_valid = 1'b0; ex_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("records_drained", 64'(rec_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/issue_sequencer.md
ISSUE_SEQUENCER -- requirements
Module: issue_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_WIDTH, default 3, issue lanes per bundle; REG_WIDTH, default 5, register index width; INST_WIDTH, default 32, instruction word width.
REQ-002 Ports SHALL be, in order (name  direction  width  meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  asynchronous, active-high reset
 flush  in  1  synchronous buffer clear (redirect)
 in_valid  in  1  fetch bundle valid
 in_ready  out  1  sequencer accepts bundle this cycle
 in_count  in  2  valid slots in bundle, lowest-index first
 in_inst  in  NUM_WIDTH x INST_WIDTH  bundle instructions
 in_rd / in_rs1 / in_rs2  in  NUM_WIDTH x REG_WIDTH  bundle register fields
 chk_rd / chk_rs1 / chk_rs2  out  NUM_WIDTH x REG_WIDTH  held slot fields to the cross-dependency checker
 dep_can_issue  in  NUM_WIDTH  checker result, combinational from chk_*
 ex_ready  in  1  execute stage accepts issue this cycle
 iss_valid  out  NUM_WIDTH  per-lane issue strobe
 iss_inst / iss_rd / iss_rs1 / iss_rs2  out  per lane  issued instruction and fields
 perf_split_cnt  out  8  saturating count of dependency-split issue cycles
REQ-003 One clock domain; rst asynchronous active-high, as already decided.

Function
REQ-004 Holding buffer SHALL have NUM_WIDTH slots (inst, rd, rs1, rs2, valid bit); slot 0 is oldest.
REQ-005 FSM SHALL have two states: IDLE (no valid slot), ACTIVE (>=1 valid slot).
REQ-006 chk_* SHALL present registered slot fields; invalid slots SHALL drive all-zero fields.
REQ-007 Lane i issue condition: slot_v[i] & ex_ready & !flush & dep_can_issue[i] & issue condition of every lane j<i; lane 0 ignores dep_can_issue.
REQ-008 iss_valid SHALL equal the issue mask combinationally; iss_* data SHALL equal slot i contents.
REQ-009 Issued set is always a prefix; n_iss = popcount(mask).
REQ-010 At the clock edge, unissued slots SHALL shift down by n_iss, preserving order; vacated top slots become invalid.
REQ-011 in_ready SHALL be 1 when !flush and (state IDLE or every valid slot issues this cycle).
REQ-012 Accept on in_valid & in_ready; in_count clamped to NUM_WIDTH; slots >= in_count loaded invalid; in_count = 0 treated as no bundle (state unchanged).
REQ-013 Simultaneous final issue and accept SHALL load the new bundle; state remains ACTIVE, no IDLE bubble.
REQ-014 Latency: bundle accepted at edge N SHALL be eligible on iss_valid in cycle N+1.
REQ-015 ex_ready = 0: iss_valid all 0, buffer held, in_ready 0 while ACTIVE.
REQ-016 flush SHALL have highest priority: iss_valid 0 and in_ready 0 that cycle; all slots invalidated at edge; next state IDLE; perf_split_cnt unchanged.
REQ-017 FSM transitions: IDLE->ACTIVE on accept; ACTIVE->IDLE when all valid slots issue and no accept, or on flush; otherwise hold.
REQ-018 perf_split_cnt SHALL increment when 0 < n_iss < valid slot count; saturates at 255.

Reset
REQ-019 rst asserted SHALL immediately force: all slot valids 0, state IDLE, perf_split_cnt 0, iss_valid 0; in_ready 1 once rst deasserts.
REQ-020 rst mid-bundle SHALL discard held instructions; none issued after release without a new accept.

Verification
REQ-021 Independent bundle: in_count=3, rd={1,2,3}, rs={0}, can_issue=111, ex_ready=1 -> cycle N+1 iss_valid=111, in_ready=1, split_cnt=0.
REQ-022 RAW split: rd0=5, rs1_1=5, can_issue=100 -> cycle N+1 iss_valid=001; N+2 slots 1,2 shifted to lanes 0,1, iss_valid=011; split_cnt=1.
REQ-023 Back-pressure: ex_ready=0 for 4 cycles with 3 held slots -> iss_valid=000, in_ready=0, chk_* unchanged; ex_ready=1 -> issue resumes.
REQ-024 Back-to-back: every valid slot issues while in_valid=1 -> new bundle loaded same edge, iss_valid non-zero next cycle, no IDLE cycle.
REQ-025 Flush with 2 held slots and in_valid=1 -> iss_valid=000, in_ready=0, next cycle state IDLE, nothing issued.
REQ-026 Saturation: 260 split cycles -> perf_split_cnt=255; async rst mid-cycle -> cnt 0, iss_valid 0 without a clock edge.
